// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the counter run controller: state encoding,
// default timing constants and the key-command priority resolver.
package count_ctrl_pkg;

    // FSM state encoding, also driven onto the debug LEDs
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Defaults for a 50 MHz board clock
    localparam int TICK_DIV_DEF   = 50_000_000;
    localparam int DEB_CYCLES_DEF = 500_000;
    localparam int LIMIT_DEF      = 9;

    // One-cycle command strobes after priority resolution
    typedef struct packed {
        logic clr;
        logic stop;
        logic start;
    } cmd_t;

    // clr beats stop beats start; losers in the same cycle are dropped
    function automatic cmd_t resolve_cmd(input logic clr, input logic stop,
                                         input logic start);
        cmd_t c;
        c.clr   = clr;
        c.stop  = stop & ~clr;
        c.start = start & ~clr & ~stop;
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-flop synchronizer, level debouncer and a
// one-cycle press pulse on the debounced 1->0 (press) transition.
module key_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous key into the clk domain; idle level is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync_b;
                    stable_cnt <= '0;
                    press      <= ~sync_b;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Run controller for the decimal counter path: turns debounced key presses
// into start/stop/clear commands, runs the tick prescaler and issues
// single-cycle increment and clear pulses to the counter.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int LIMIT      = LIMIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_stop,
    input  logic       key_clr,
    input  logic       wrap,
    input  logic [3:0] cont,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic       done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    LIMIT_V  = 4'(LIMIT);

    logic          press_start;
    logic          press_stop;
    logic          press_clr;
    cmd_t          cmd;
    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nxt;
    logic [1:0]    state_nxt;
    logic          en_nxt;
    logic          clr_nxt;
    logic          tick;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst(rst), .key(key_start), .press(press_start)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .clk(clk), .rst(rst), .key(key_stop), .press(press_stop)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst(rst), .key(key_clr), .press(press_clr)
    );

    assign cmd  = resolve_cmd(press_clr, press_stop, press_start);
    assign tick = (state == ST_RUN) && (pre == PRE_LAST);

    // Next-state, prescaler and pulse decisions for the current cycle
    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        en_nxt    = 1'b0;
        clr_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd.clr) begin
                    clr_nxt = 1'b1;
                end else if (cmd.start) begin
                    state_nxt = ST_RUN;
                    pre_nxt   = '0;
                end
            end
            ST_RUN: begin
                // The prescaler keeps counting in a stop cycle, so a tick
                // landing there is consumed rather than replayed on resume.
                pre_nxt = tick ? '0 : pre + PW'(1);
                if (cmd.clr) begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                end else if (cmd.stop) begin
                    state_nxt = ST_PAUSE;
                end else if (tick) begin
                    if (cont != LIMIT_V) begin
                        en_nxt = 1'b1;
                    end else if (wrap) begin
                        clr_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (cmd.clr) begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                end else if (cmd.start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (cmd.clr) begin
                    state_nxt = ST_IDLE;
                    clr_nxt   = 1'b1;
                end else if (cmd.start) begin
                    state_nxt = ST_RUN;
                    clr_nxt   = 1'b1;
                    pre_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered state, prescaler and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            pre     <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pre     <= pre_nxt;
            cnt_en  <= en_nxt;
            cnt_clr <= clr_nxt;
            done    <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl with a companion mod-10 counter model. Expected
// counter pulses are queued when stimulus is applied and compared against
// the pulses the DUT actually produces.
module tb_count_ctrl;

    localparam int TICK_DIV   = 10;
    localparam int DEB_CYCLES = 4;
    localparam int LIMIT      = 9;
    localparam int PRESS_LAT  = 7;

    localparam logic [1:0] K_EN  = 2'b01;
    localparam logic [1:0] K_CLR = 2'b10;

    typedef struct {
        int         cyc;
        logic [1:0] kind;
        logic [1:0] st;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_stop;
    logic       key_clr;
    logic       wrap;
    logic [3:0] cont;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] state;
    logic       done;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    count_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES), .LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .key_start(key_start), .key_stop(key_stop),
        .key_clr(key_clr), .wrap(wrap), .cont(cont), .cnt_en(cnt_en),
        .cnt_clr(cnt_clr), .state(state), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Companion counter: decimal digit driven by the controller pulses
    always @(posedge clk or negedge rst) begin
        if (!rst) cont <= 4'd0;
        else if (cnt_clr) cont <= 4'd0;
        else if (cnt_en) cont <= (cont == 4'd9) ? 4'd0 : cont + 4'd1;
    end

    // Record every pulse the DUT emits, with the state shown alongside it
    always @(posedge clk) begin
        #1;
        if (rst && (cnt_en || cnt_clr))
            obs_q.push_back('{cyc: cyc, kind: {cnt_clr, cnt_en}, st: state});
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, cyc=%0d required < 50000", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Hold the masked keys low for 'hold' cycles (bit0 start, bit1 stop, bit2 clr)
    task automatic press_keys(input logic [2:0] mask, input int hold);
        key_start = ~mask[0];
        key_stop  = ~mask[1];
        key_clr   = ~mask[2];
        repeat (hold) tick();
        key_start = 1'b1;
        key_stop  = 1'b1;
        key_clr   = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        key_start = 1'b1;
        key_stop  = 1'b1;
        key_clr   = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        int t;
        int s;
        rst = 1'b0; key_start = 1'b0; key_stop = 1'b0; key_clr = 1'b0; wrap = 1'b1;
        repeat (3) tick();
        n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_en: got %b expected 0", cnt_en); end
        n_chk++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_clr: got %b expected 0", cnt_clr); end
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        do_reset();
        t = cyc;
        s = t + PRESS_LAT;
        for (int k = 1; k <= 3; k++) exp_q.push_back('{cyc: s + k * TICK_DIV, kind: K_EN, st: 2'd1});
        press_keys(3'b001, 6);
        wait_until(s - 1);
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL start_early: state %0d at cycle %0d, expected 0", state, cyc - t); end
        tick();
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_latency: state %0d at cycle %0d, expected 1", state, cyc - t); end
        wait_until(s + 3 * TICK_DIV + 3);
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL reset_pulse_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            n_chk++;
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.st !== e.st) begin
                n_fail++;
                $display("FAIL reset_pulse: got cyc %0d kind %b st %0d, expected cyc %0d kind %b st %0d", o.cyc, o.kind, o.st, e.cyc, e.kind, e.st);
            end
        end
    endtask

    task automatic test_wrap();
        int t;
        int s;
        int mc;
        do_reset();
        wrap = 1'b1;
        t = cyc;
        s = t + PRESS_LAT;
        mc = 0;
        for (int k = 1; k <= 11; k++) begin
            if (mc != LIMIT) begin
                exp_q.push_back('{cyc: s + k * TICK_DIV, kind: K_EN, st: 2'd1});
                mc++;
            end else begin
                exp_q.push_back('{cyc: s + k * TICK_DIV, kind: K_CLR, st: 2'd1});
                mc = 0;
            end
        end
        press_keys(3'b001, 6);
        wait_until(s + 11 * TICK_DIV + 3);
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL wrap_state: got %0d expected 1", state); end
        n_chk++; if (cont !== 4'(mc)) begin n_fail++; $display("FAIL wrap_cont: got %0d expected %0d", cont, mc); end
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_pulse_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            n_chk++;
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.st !== e.st) begin
                n_fail++;
                $display("FAIL wrap_pulse: got cyc %0d kind %b st %0d, expected cyc %0d kind %b st %0d", o.cyc, o.kind, o.st, e.cyc, e.kind, e.st);
            end
        end
    endtask

    task automatic test_halt();
        int t;
        int s;
        do_reset();
        wrap = 1'b0;
        t = cyc;
        s = t + PRESS_LAT;
        for (int k = 1; k <= LIMIT; k++) exp_q.push_back('{cyc: s + k * TICK_DIV, kind: K_EN, st: 2'd1});
        press_keys(3'b001, 6);
        wait_until(s + 10 * TICK_DIV - 1);
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL halt_before: state %0d expected 1", state); end
        wait_until(s + 10 * TICK_DIV + 4);
        n_chk++; if (state !== 2'd3) begin n_fail++; $display("FAIL halt_state: got %0d expected 3", state); end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %b expected 1", done); end
        n_chk++; if (cont !== 4'd9) begin n_fail++; $display("FAIL halt_cont: got %0d expected 9", cont); end
        // stop is ignored in DONE
        t = cyc;
        press_keys(3'b010, 6);
        wait_until(t + PRESS_LAT + 3);
        n_chk++; if (state !== 2'd3) begin n_fail++; $display("FAIL done_stop: state %0d expected 3", state); end
        // start from DONE restarts with a clear
        t = cyc;
        exp_q.push_back('{cyc: t + PRESS_LAT, kind: K_CLR, st: 2'd1});
        press_keys(3'b001, 6);
        wait_until(t + PRESS_LAT);
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL restart_state: got %0d expected 1", state); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b expected 0", done); end
        wait_until(t + PRESS_LAT + 3);
        n_chk++; if (cont !== 4'd0) begin n_fail++; $display("FAIL restart_cont: got %0d expected 0", cont); end
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL halt_pulse_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            n_chk++;
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.st !== e.st) begin
                n_fail++;
                $display("FAIL halt_pulse: got cyc %0d kind %b st %0d, expected cyc %0d kind %b st %0d", o.cyc, o.kind, o.st, e.cyc, e.kind, e.st);
            end
        end
    endtask

    task automatic test_pause_resume();
        int t;
        int s;
        int r;
        do_reset();
        wrap = 1'b1;
        t = cyc;
        s = t + PRESS_LAT;
        press_keys(3'b001, 6);
        wait_until(s);
        // stop pulse lands when the prescaler reads 6
        press_keys(3'b010, 6);
        wait_until(s + PRESS_LAT);
        n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_state: got %0d expected 2", state); end
        wait_until(s + 20);
        n_chk++; if (state !== 2'd2) begin n_fail++; $display("FAIL pause_hold: got %0d expected 2", state); end
        r = cyc;
        exp_q.push_back('{cyc: r + PRESS_LAT + 3, kind: K_EN, st: 2'd1});
        exp_q.push_back('{cyc: r + PRESS_LAT + 3 + TICK_DIV, kind: K_EN, st: 2'd1});
        press_keys(3'b001, 6);
        wait_until(r + PRESS_LAT);
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d expected 1", state); end
        wait_until(r + PRESS_LAT + 3 + TICK_DIV + 3);
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL pause_pulse_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            n_chk++;
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.st !== e.st) begin
                n_fail++;
                $display("FAIL pause_pulse: got cyc %0d kind %b st %0d, expected cyc %0d kind %b st %0d", o.cyc, o.kind, o.st, e.cyc, e.kind, e.st);
            end
        end
    endtask

    task automatic test_priority_bounce();
        int t;
        int s;
        int g;
        do_reset();
        wrap = 1'b1;
        t = cyc;
        s = t + PRESS_LAT;
        exp_q.push_back('{cyc: s + TICK_DIV, kind: K_EN, st: 2'd1});
        exp_q.push_back('{cyc: s + 12 + PRESS_LAT, kind: K_CLR, st: 2'd0});
        press_keys(3'b001, 6);
        wait_until(s + 12);
        press_keys(3'b110, 6);
        wait_until(s + 12 + PRESS_LAT);
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL prio_state: got %0d expected 0", state); end
        // short glitch on start must not move the FSM
        wait_until(s + 30);
        g = cyc;
        press_keys(3'b001, 3);
        wait_until(g + 15);
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL glitch_state: got %0d expected 0", state); end
        // clr in IDLE issues a clear and stays put
        t = cyc;
        exp_q.push_back('{cyc: t + PRESS_LAT, kind: K_CLR, st: 2'd0});
        press_keys(3'b100, 6);
        wait_until(t + PRESS_LAT + 3);
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL idle_clr_state: got %0d expected 0", state); end
        n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL prio_pulse_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front();
            ev_t o = obs_q.pop_front();
            n_chk++;
            if (o.cyc !== e.cyc || o.kind !== e.kind || o.st !== e.st) begin
                n_fail++;
                $display("FAIL prio_pulse: got cyc %0d kind %b st %0d, expected cyc %0d kind %b st %0d", o.cyc, o.kind, o.st, e.cyc, e.kind, e.st);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int t;
        int s;
        do_reset();
        wrap = 1'b1;
        t = cyc;
        s = t + PRESS_LAT;
        press_keys(3'b001, 6);
        wait_until(s + TICK_DIV);
        n_chk++; if (cnt_en !== 1'b1) begin n_fail++; $display("FAIL midrun_pulse: cnt_en %b expected 1", cnt_en); end
        rst = 1'b0;
        #1;
        n_chk++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL midrun_cnt_en: got %b expected 0", cnt_en); end
        n_chk++; if (state !== 2'd0) begin n_fail++; $display("FAIL midrun_state: got %0d expected 0", state); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; key_start = 1'b1; key_stop = 1'b1; key_clr = 1'b1; wrap = 1'b1;
        test_reset();
        test_wrap();
        test_halt();
        test_pause_resume();
        test_priority_bounce();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Run controller for the single-digit decimal counter path: the frequency divider, the mod-10 counter and the 7-segment decoder. It replaces the free-running 1 Hz clock with single-cycle enable pulses on the system clock. It turns three push-buttons into start, stop and clear commands, and sequences the counter through idle, run, pause and done. The counter becomes a synchronous, enable-driven datapath on `clk`, observed by this block through its current value.

## Interface
- `TICK_DIV`, 50_000_000: `clk` cycles per count tick (≥2).
- `DEB_CYCLES`, 500_000: consecutive stable synchronized cycles before a key level is accepted (≥1).
- `LIMIT`, 9: terminal count value (0–15).

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `rst`  in  1  asynchronous, active-low reset.
- `key_start`  in  1  start button, active-low, asynchronous to `clk`.
- `key_stop`  in  1  stop button, active-low, asynchronous.
- `key_clr`  in  1  clear button, active-low, asynchronous.
- `wrap`  in  1  level: 1 = restart from 0 after `LIMIT`, 0 = halt at `LIMIT`.
- `cont`  in  4  current counter value.
- `cnt_en`  out  1  one-cycle increment pulse to the counter.
- `cnt_clr`  out  1  one-cycle synchronous clear pulse to the counter.
- `state`  out  2  FSM state (LED debug).
- `done`  out  1  high while in DONE.

## Operation
- **Key conditioning:** each key goes through a 2-flop synchronizer and then a debouncer. The debounced level resets to 1 (released). It takes the synchronized level after that level has differed from it for `DEB_CYCLES` consecutive cycles. A 1→0 transition of the debounced level produces a one-cycle press pulse. Release produces nothing.
- **Command priority** within a cycle: clr > stop > start. Lower-priority presses in the same cycle are discarded.
- **Prescaler:** counts 0..`TICK_DIV`-1 only in RUN, and holds its value in other states.
  - A tick occurs in a RUN cycle where the prescaler equals `TICK_DIV`-1; the prescaler then returns to 0.
  - It is zeroed on entry to RUN from IDLE or DONE. It is not zeroed on resume from PAUSE.
- **IDLE (0):**
  - start → RUN.
  - clr → issue `cnt_clr`, stay IDLE.
- **RUN (1):**
  - clr → IDLE, issue `cnt_clr`.
  - stop → PAUSE. A tick in the same cycle is dropped.
  - On a tick, `cont` is sampled in the tick cycle:
    - `cont`≠`LIMIT` → issue `cnt_en`.
    - `cont`=`LIMIT` and `wrap`=1 → issue `cnt_clr` (no `cnt_en`), stay RUN.
    - `cont`=`LIMIT` and `wrap`=0 → DONE, no pulse.
- **PAUSE (2):**
  - start → RUN.
  - clr → IDLE, issue `cnt_clr`.
- **DONE (3):**
  - `done`=1.
  - start → RUN, issue `cnt_clr` (restart).
  - clr → IDLE, issue `cnt_clr`.
  - stop is ignored.
- `cnt_en` and `cnt_clr` are never high in the same cycle.
- `cont` > `LIMIT` (e.g. a counter left in an odd state) is treated as ≠`LIMIT`. The counter's own modulus governs its value.

## Timing
- All outputs are registered.
- Reset values:
  - `cnt_en`=0, `cnt_clr`=0, `state`=0 (IDLE), `done`=0.
  - Prescaler = 0; debounced levels = 1; synchronizers = 1.
- Press latency:
  - A key held low from cycle t produces its press pulse at cycle t+2+`DEB_CYCLES`.
  - The state change is visible at `state` one cycle after the press pulse.
- Tick latency:
  - The first `cnt_en` after entering RUN from IDLE asserts `TICK_DIV` cycles after `state` shows RUN.
  - Subsequent pulses follow every `TICK_DIV` cycles.
  - Each `cnt_en` is high for exactly 1 cycle. `cnt_clr` is also exactly 1 cycle.
- Issued pulses appear in the cycle after the deciding event, together with the new `state`.
- Reset asserted mid-run immediately clears all outputs and the state. A pulse in flight is cut short.
- Key bounce shorter than `DEB_CYCLES` produces no press.

## Structure
- Package `count_ctrl_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3);
  - default parameter constants.
- Sub-module `key_debounce`: synchronizer, debounce counter and press pulse, parameterized by `DEB_CYCLES`. It is instantiated three times.
- FSM, prescaler and output registers live in `count_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=10, `DEB_CYCLES`=4, `LIMIT`=9, with a companion counter model.
- **Reset:** hold `rst`=0 → all outputs 0, `state`=0. Release, then press start → `state`=1 at 7 cycles after the press began. First `cnt_en` follows 10 cycles later, then every 10 cycles.
- **Wrap:** `wrap`=1, run through 10 ticks → counter 0..9. The tick at `cont`=9 gives `cnt_clr` with no `cnt_en`; counter returns to 0 and `state` stays 1.
- **Halt at limit:** `wrap`=0, run until `cont`=9 → next tick gives `state`=3, `done`=1, no pulse. Start → `cnt_clr` plus `state`=1.
- **Pause/resume:** stop at prescaler=6 → `state`=2, no `cnt_en`. Start → first `cnt_en` after 3 more cycles in RUN.
- **Priority and bounce:** clr and stop pressed together in RUN → `state`=0 and one `cnt_clr`. A 3-cycle glitch on `key_start` → no state change.
